// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg
// Shared sizing helpers for the bit-serial subtractor.
// No ports; imported by serial_subtractor.
package serial_subtractor_pkg;

    // State register width for the IDLE/SHIFT/DONE controller.
    localparam int STATE_W = 2;

    // The bit counter holds 0..WIDTH-1 plus one spare bit of headroom.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// Half_Subtractor / Full_Subtractor
// One-bit subtract cells used by the serial subtractor datapath.
// Half_Subtractor ports:
//   A, B  : input  operand bits (computes A - B)
//   D     : output difference bit
//   Bout  : output borrow
// Full_Subtractor ports:
//   A, B  : input  operand bits (computes A - B - Bin)
//   Bin   : input  incoming borrow
//   D     : output difference bit
//   Bout  : output outgoing borrow
module Half_Subtractor (
    input  logic A,
    input  logic B,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B;
    assign Bout = ~A & B;
endmodule

module Full_Subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    logic d_first;
    logic b_first;
    logic b_second;

    Half_Subtractor u_hs_ab (
        .A    (A),
        .B    (B),
        .D    (d_first),
        .Bout (b_first)
    );

    // Second stage subtracts the incoming borrow from the partial difference;
    // its borrow equals ~(A ^ B) & Bin.
    Half_Subtractor u_hs_bin (
        .A    (d_first),
        .B    (Bin),
        .D    (D),
        .Bout (b_second)
    );

    assign Bout = b_first | b_second;
endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial, LSB-first subtractor: D = A - B mod 2^WIDTH, Bout = (A < B).
// One result every WIDTH+2 cycles when start is held high.
// Ports:
//   clk   : input  clock, rising edge
//   rst_n : input  asynchronous active-low reset
//   start : input  request, sampled only in IDLE
//   A, B  : input  [WIDTH-1:0] operands, captured on the accepted start edge
//   busy  : output high in SHIFT or DONE
//   done  : output one-cycle pulse, result valid
//   D     : output [WIDTH-1:0] difference, updated only entering DONE
//   Bout  : output final borrow, updated only entering DONE
//
// state | meaning
// IDLE  | waiting for start; D/Bout hold last result
// SHIFT | one bit of A-B per cycle, WIDTH cycles
// DONE  | result presented, done pulse
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout
);
    localparam int CW = cnt_width(WIDTH);

    localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
    localparam logic [STATE_W-1:0] S_SHIFT = 2'd1;
    localparam logic [STATE_W-1:0] S_DONE  = 2'd2;

    logic [STATE_W-1:0] state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [WIDTH-1:0]   r_sr;
    logic [WIDTH-1:0]   r_next;
    logic               borrow;
    logic               bit_d;
    logic               bit_b;
    logic               last;

    Full_Subtractor u_fs (
        .A    (a_sr[0]),
        .B    (b_sr[0]),
        .Bin  (borrow),
        .D    (bit_d),
        .Bout (bit_b)
    );

    // Difference bits enter at the MSB so after WIDTH steps the LSB-first
    // stream lines up with bit positions; written this way it also holds for WIDTH=1.
    assign r_next = (r_sr >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
    assign last   = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            borrow <= 1'b0;
            D      <= '0;
            Bout   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr   <= A;
                        b_sr   <= B;
                        r_sr   <= '0;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    r_sr   <= r_next;
                    borrow <= bit_b;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        // Outputs change only here, so D never shows a partial result.
                        D     <= r_next;
                        Bout  <= bit_b;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_SHIFT) || (state == S_DONE);
    assign done = (state == S_DONE);

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand and result width in bits (legal range 1 to 32).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port start, input, 1, request to subtract B from A; sampled only in IDLE.
REQ-005 SHALL have port A, input, WIDTH, minuend; captured on the accepted start edge.
REQ-006 SHALL have port B, input, WIDTH, subtrahend; captured on the accepted start edge.
REQ-007 SHALL have port busy, output, 1, high while in SHIFT or DONE.
REQ-008 SHALL have port done, output, 1, one-cycle pulse marking a valid result.
REQ-009 SHALL have port D, output, WIDTH, difference A-B modulo 2^WIDTH.
REQ-010 SHALL have port Bout, output, 1, final borrow; high iff A < B unsigned.

Function
REQ-011 SHALL implement a 3-state FSM: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 SHALL load A and B into internal shift registers, clear borrow flop, clear bit counter, and move to SHIFT.
REQ-013 IDLE with start=0 SHALL remain in IDLE and hold D and Bout.
REQ-014 Each SHIFT cycle SHALL perform one LSB-first full-subtract step: diff = a0 XOR b0 XOR borrow; borrow_next = (~a0 & b0) | (~(a0 XOR b0) & borrow).
REQ-015 Each SHIFT cycle SHALL shift both operand registers right by one and shift diff into the MSB of the result register.
REQ-016 SHALL stay in SHIFT for exactly WIDTH cycles, counter 0 to WIDTH-1, then move to DONE.
REQ-017 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-018 Latency: start accepted at edge k SHALL give done=1 in the cycle after edge k+WIDTH.
REQ-019 D and Bout SHALL update only on the edge entering DONE and SHALL hold until the next DONE.
REQ-020 D SHALL never present partial results; shifting happens in an internal register.
REQ-021 start while busy, including the DONE cycle, SHALL be ignored, not queued.
REQ-022 start in the IDLE cycle right after DONE SHALL be accepted, so the back-to-back period is WIDTH+2 cycles.
REQ-023 A and B changing after the accepted start edge SHALL NOT affect the running operation.
REQ-024 WIDTH=1 SHALL give one SHIFT cycle; D = A XOR B; Bout = ~A & B.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, busy=0, done=0, D=0, Bout=0, and clear counter, borrow and shift registers, independent of clk.
REQ-026 Reset mid-operation SHALL discard the operation; no done pulse after release.
REQ-027 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted normally.

Structure
REQ-028 FSM state encodings SHALL be localparams in the module; no shared package is required.
REQ-029 The per-bit step SHALL be one instantiated sub-module, Full_Subtractor, with inputs A, B, Bin and outputs D, Bout.
REQ-030 Full_Subtractor SHALL be built from two existing half-subtractor instances plus an OR of their borrows.
REQ-031 Counter width SHALL be clog2(WIDTH)+1 bits.

Verification
REQ-032 WIDTH=8, A=0x5A, B=0x3C, start pulse -> done after 9 edges; D=0x1E, Bout=0.
REQ-033 WIDTH=8, A=0x00, B=0x01 -> D=0xFF, Bout=1; then A=0xFF, B=0xFF -> D=0x00, Bout=0.
REQ-034 start held high continuously with A=0x10, B=0x01 -> exactly one done per 10 cycles, D=0x0F each time; start during SHIFT/DONE ignored.
REQ-035 rst_n pulsed low at the 4th SHIFT cycle -> busy=0, D=0 immediately; no done; next operation 0x80-0x7F gives D=0x01, Bout=0.
REQ-036 A/B changed to 0xAA/0x55 one cycle after start of 0x33-0x11 -> D=0x22, Bout=0.
REQ-037 WIDTH=1, all four A/B combinations -> done after 2 edges; D/Bout = 0/0, 1/0, 1/1, 0/0 for (A,B)=00, 10, 01, 11.
